// File: rtl/lcd_text_ctrl.sv
// ---------------------------------------------------------------------------
// lcd_text_ctrl
//   HD44780-style character LCD controller. It holds a writable ROWS x COLS
//   character buffer. After reset it runs the power-up init sequence, then
//   redraws the whole panel each time UPDATE is requested.
//
//   Each bus transfer spans three step ticks:
//     SETUP - E high, with RS and DB driven
//     DROP  - E low; the LCD latches the byte
//     HOLD  - RS and DB are held, then the next item is selected
//
//   Parameters
//     TICK_DIV  CLK cycles per step tick (>= 2)
//     COLS      characters per row (1..40)
//     ROWS      display rows (1, 2 or 4)
//     AW        WR_ADDR width, 2^AW >= ROWS*COLS
//
//   Ports
//     CLK, RST    clock; synchronous active-low reset
//     WR_EN       buffer write strobe
//     WR_ADDR     buffer index (row*COLS + col); out-of-range writes are dropped
//     WR_DATA     character code
//     UPDATE      single-cycle redraw request
//     BUSY        init or redraw in progress
//     INIT_DONE   init sequence finished
//     LCD_RS      0 = command, 1 = data
//     LCD_RW      always 0 (write only)
//     LCD_E       enable strobe
//     LCD_ON      panel power/backlight, set from the first DROP onward
//     LCD_DB      8-bit data bus
//
//   Build option
//     LCD_AUTO_REFRESH_EN - when defined, a new redraw starts right after init
//     and after every redraw, so the panel refreshes continuously.
// ---------------------------------------------------------------------------
module lcd_text_ctrl #(
    parameter int TICK_DIV = 62500,
    parameter int COLS     = 16,
    parameter int ROWS     = 2,
    parameter int AW       = 7
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          WR_EN,
    input  logic [AW-1:0] WR_ADDR,
    input  logic [7:0]    WR_DATA,
    input  logic          UPDATE,
    output logic          BUSY,
    output logic          INIT_DONE,
    output logic          LCD_RS,
    output logic          LCD_RW,
    output logic          LCD_E,
    output logic          LCD_ON,
    output logic [7:0]    LCD_DB
);

    localparam int NCHARS = ROWS * COLS;
    localparam int IW     = (NCHARS > 1) ? $clog2(NCHARS) : 1;
    localparam int CW     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [AW:0] NCHARS_W = NCHARS[AW:0];

`ifdef LCD_AUTO_REFRESH_EN
    localparam bit AUTO_REFRESH = 1'b1;
`else
    localparam bit AUTO_REFRESH = 1'b0;
`endif

    typedef enum logic [1:0] {S_INIT, S_IDLE, S_ROW, S_CHAR} state_t;
    typedef enum logic [1:0] {P_SETUP, P_DROP, P_HOLD} phase_t;

    // ------------------------------------------------------------------
    // Step tick
    // ------------------------------------------------------------------
    logic [CW-1:0] tick_cnt;
    logic          tick;

    assign tick = (tick_cnt == CW'(TICK_DIV - 1));

    always_ff @(posedge CLK) begin
        if (!RST)
            tick_cnt <= '0;
        else if (tick)
            tick_cnt <= '0;
        else
            tick_cnt <= tick_cnt + CW'(1);
    end

    // ------------------------------------------------------------------
    // Character buffer. The redraw samples an entry at that character's
    // SETUP tick. A write on the same edge lands afterwards, so the old
    // value is sent.
    // ------------------------------------------------------------------
    logic [7:0] char_buf [NCHARS];

    always_ff @(posedge CLK) begin
        if (!RST) begin
            for (int i = 0; i < NCHARS; i++)
                char_buf[i] <= 8'h20;
        end else if (WR_EN && ({1'b0, WR_ADDR} < NCHARS_W)) begin
            char_buf[WR_ADDR[IW-1:0]] <= WR_DATA;
        end
    end

    // ------------------------------------------------------------------
    // Command tables
    // ------------------------------------------------------------------
    function automatic logic [7:0] init_cmd(input logic [2:0] idx);
        case (idx)
            3'd0, 3'd1, 3'd2, 3'd3: return 8'h38;
            3'd4:                   return 8'h08;
            3'd5:                   return 8'h01;
            3'd6:                   return 8'h0C;
            default:                return 8'h06;
        endcase
    endfunction

    function automatic logic [7:0] row_cmd(input logic [1:0] r);
        case (r)
            2'd0:    return 8'h80;
            2'd1:    return 8'hC0;
            2'd2:    return 8'h94;
            default: return 8'hD4;
        endcase
    endfunction

    // ------------------------------------------------------------------
    // Sequencer
    // ------------------------------------------------------------------
    state_t        state;
    phase_t        phase;
    logic [2:0]    init_idx;
    logic [1:0]    row;
    logic [5:0]    col;
    logic [IW-1:0] chr;      // running buffer index, row*COLS+col
    logic          pending;

    logic [7:0]    xfer_db;
    logic          xfer_rs;
    logic          start_req;

    // Pending is cleared in the same cycle that a redraw is launched. An
    // UPDATE arriving in that cycle is therefore folded into the launch
    // through start_req and is not left behind as a stale pending flag.
    assign start_req = UPDATE || pending || AUTO_REFRESH;

    always_comb begin
        xfer_db = 8'h00;
        xfer_rs = 1'b0;
        case (state)
            S_INIT: xfer_db = init_cmd(init_idx);
            S_ROW:  xfer_db = row_cmd(row);
            S_CHAR: begin
                xfer_db = char_buf[chr];
                xfer_rs = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state     <= S_INIT;
            phase     <= P_SETUP;
            init_idx  <= '0;
            row       <= '0;
            col       <= '0;
            chr       <= '0;
            pending   <= 1'b0;
            BUSY      <= 1'b1;
            INIT_DONE <= 1'b0;
            LCD_E     <= 1'b0;
            LCD_RS    <= 1'b0;
            LCD_DB    <= 8'h00;
            LCD_ON    <= 1'b0;
        end else begin
            if (UPDATE && (state != S_IDLE))
                pending <= 1'b1;

            if (state == S_IDLE) begin
                // Leave IDLE on any cycle. The first transfer then waits
                // for the next tick.
                if (start_req) begin
                    state   <= S_ROW;
                    phase   <= P_SETUP;
                    row     <= '0;
                    col     <= '0;
                    chr     <= '0;
                    pending <= 1'b0;
                    BUSY    <= 1'b1;
                end
            end else if (tick) begin
                case (phase)
                    P_SETUP: begin
                        LCD_E  <= 1'b1;
                        LCD_RS <= xfer_rs;
                        LCD_DB <= xfer_db;
                        phase  <= P_DROP;
                    end
                    P_DROP: begin
                        LCD_E  <= 1'b0;
                        LCD_ON <= 1'b1;
                        phase  <= P_HOLD;
                    end
                    default: begin
                        phase <= P_SETUP;
                        case (state)
                            S_INIT: begin
                                if (init_idx == 3'd7) begin
                                    INIT_DONE <= 1'b1;
                                    if (start_req) begin
                                        state   <= S_ROW;
                                        row     <= '0;
                                        col     <= '0;
                                        chr     <= '0;
                                        pending <= 1'b0;
                                    end else begin
                                        state <= S_IDLE;
                                        BUSY  <= 1'b0;
                                    end
                                end else begin
                                    init_idx <= init_idx + 3'd1;
                                end
                            end
                            S_ROW: begin
                                state <= S_CHAR;
                                col   <= '0;
                            end
                            default: begin
                                chr <= chr + IW'(1);
                                if (col == 6'(COLS - 1)) begin
                                    col <= '0;
                                    if (row == 2'(ROWS - 1)) begin
                                        // End of the panel. Chain straight
                                        // into another redraw if one was
                                        // requested, so BUSY never drops.
                                        if (start_req) begin
                                            state   <= S_ROW;
                                            row     <= '0;
                                            chr     <= '0;
                                            pending <= 1'b0;
                                        end else begin
                                            state <= S_IDLE;
                                            BUSY  <= 1'b0;
                                        end
                                    end else begin
                                        row   <= row + 2'd1;
                                        state <= S_ROW;
                                    end
                                end else begin
                                    col <= col + 6'd1;
                                end
                            end
                        endcase
                    end
                endcase
            end
        end
    end

    assign LCD_RW = 1'b0;

endmodule

// File: doc/lcd_text_ctrl.md
Name: lcd_text_ctrl

Overview:
- Parametrised HD44780-style character LCD controller; successor to the fixed 16x2, fixed-message LCD driver.
- Holds a writable ROWS x COLS character buffer, written by upstream logic (game/menu FSM) through a simple write port.
- Runs the LCD power-up init sequence, then redraws the whole panel on request.
- Supports 1, 2 or 4 rows, any column count up to 40, and a parametrised step rate.

Parameters:
- TICK_DIV, 62500, CLK cycles per LCD step tick (400 Hz at 25 MHz); legal range 2 or more.
- COLS, 16, characters per row; legal range 1..40.
- ROWS, 2, display rows; legal values 1, 2, 4.
- AW, 7, WR_ADDR width; must satisfy 2^AW >= ROWS*COLS.

Ports:
- CLK  in  1  system clock
- RST  in  1  reset, synchronous, active-low
- WR_EN  in  1  buffer write strobe
- WR_ADDR  in  AW  buffer index, row*COLS+col
- WR_DATA  in  8  character code
- UPDATE  in  1  single-cycle redraw request
- BUSY  out  1  init or redraw in progress
- INIT_DONE  out  1  init sequence complete
- LCD_RS  out  1  0 = command, 1 = data
- LCD_RW  out  1  tied 0 (write only)
- LCD_E  out  1  enable strobe
- LCD_ON  out  1  panel power/backlight enable
- LCD_DB  out  8  data bus

Behaviour:
- Reset (RST=0 at a CLK edge) values:
  - LCD_E=0, LCD_RS=0, LCD_RW=0, LCD_DB=8'h00, LCD_ON=0.
  - BUSY=1, INIT_DONE=0.
  - Tick counter=0, pending flag=0.
  - Every buffer entry = 8'h20 (space).
  - FSM goes to the first INIT command.
  - Reset mid-init or mid-redraw aborts immediately; no partial transfer is completed.
- Tick: the counter counts 0..TICK_DIV-1 and a 1-cycle tick fires when count==TICK_DIV-1. The FSM advances only on ticks.
- Every transfer takes 3 ticks:
  - SETUP: E=1, RS and DB driven.
  - DROP: E=0; LCD_ON latches to 1.
  - HOLD: DB and RS held, then move to the next item.
- Init sequence: commands 38,38,38,38,08,01,0C,06 (8 transfers, 24 ticks), then INIT_DONE=1, BUSY=0, state IDLE.
- Redraw:
  - Per row r: a set-DDRAM command is sent with base address 80, C0, 94, D4 for r = 0..3.
  - Then COLS data transfers (RS=1) follow, in column order.
  - After the last character of the last row: IDLE, BUSY=0.
  - Total redraw = ROWS*(COLS+1)*3 ticks.
- Character sampling: each character is read from the buffer at its SETUP tick. A write on that same cycle to the same address is not seen; the old value is sent.
- UPDATE handling:
  - In IDLE: BUSY goes to 1 on the next cycle and the redraw starts at the next tick.
  - During redraw or init: sets the one-deep pending flag. Extra requests merge into it.
  - On reaching IDLE with pending=1: pending clears and a new redraw starts without BUSY dropping.
  - UPDATE during init is serviced after init.
- Writes:
  - Accepted on any cycle, including while BUSY.
  - WR_ADDR >= ROWS*COLS is ignored.
  - Simultaneous WR_EN and UPDATE: the write lands before the redraw samples that address.
- LCD_RW is always 0.

Optional Feature:
- Macro: LCD_AUTO_REFRESH_EN.
- Defined: after init and after every redraw, the FSM immediately starts another redraw (continuous refresh). BUSY stays 1 after the first redraw, and UPDATE is accepted but has no additional effect.
- Undefined: a redraw happens only on UPDATE.

Test Plan:
- Reset, then TICK_DIV=4, ROWS=2, COLS=16 -> 8 E falling edges carrying DB 38,38,38,38,08,01,0C,06 with RS=0; INIT_DONE=1 after 24 ticks (96 cycles); LCD_ON=1 from the first DROP.
- Write "HI" at addresses 0,1 and 'X' at 16, then pulse UPDATE -> sequence 80, 48, 49, then 14 transfers of 20, then C0, 58, then 15 transfers of 20; BUSY high for exactly 102 ticks.
- UPDATE pulsed three times during a redraw -> exactly one further redraw, with BUSY continuously 1 between them.
- WR_ADDR=32 with ROWS*COLS=32 -> buffer unchanged; the next redraw shows all spaces.
- ROWS=4, COLS=20 -> row commands 80, C0, 94, D4, each followed by 20 data transfers.
- RST asserted at the 5th data transfer of a redraw -> next cycle E=0, DB=00, BUSY=1; the init sequence restarts and the buffer reads all 20.
